trap_unit: RTL and testbench
============================

# trap_unit

Parametrised machine-mode trap controller for the 5-stage RV32 core, sitting beside the MEM stage. It owns the machine CSR file (mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval), arbitrates synchronous exceptions against NUM_IRQ level-sensitive platform interrupts, and sequences trap entry and mret through a small state machine. It drives pipeline flushes and a one-cycle PC redirect, with direct or vectored mtvec dispatch.

## Interface
- NUM_IRQ, 4, platform interrupt lines, legal 1..16, mapped to mip/mie bits 16+i
- RESET_MTVEC, 32'h0000_0000, mtvec value after reset
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- csr_rw  in  1  CSR instruction valid in MEM
- csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 no write
- csr_addr  in  12  CSR address
- csr_wdata  in  32  write/set/clear operand (register or zero-extended imm, muxed upstream)
- csr_rdata  out  32  combinational read of csr_addr
- irq_in  in  NUM_IRQ  level interrupt requests
- illegal_inst, ecall_m, l_access_fault, s_access_fault  in  1 each  exceptions from MEM
- mret  in  1  mret in MEM
- fault_addr  in  32  memory address for access faults
- inst_bits  in  32  instruction word for illegal_inst
- epc_cur  in  32  PC of the instruction in MEM
- epc_next  in  32  oldest unflushed PC after MEM (interrupt return point)
- pc_redirect  out  32  redirect target
- redirect_valid  out  1  take pc_redirect this cycle
- flush_fd, flush_de, flush_em, flush_mw  out  1 each  pipeline register flushes
- regwrite_cancel  out  1  suppress WB write of the trapping instruction
- trap_busy  out  1  state != IDLE

## Operation
- CSR map: 0x300 mstatus (only MIE bit3, MPIE bit7 writable; MPP reads 2'b11), 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc (bits[1:0] forced 0), 0x342 mcause, 0x343 mtval, 0x344 mip (read-only, bit 16+i = irq_in[i]). Other addresses read 0, writes ignored. mie bits outside 16..16+NUM_IRQ-1 read 0.
- Event priority in IDLE: illegal_inst (cause 2, mtval=inst_bits) > ecall_m (11, mtval 0) > l_access_fault (5, mtval=fault_addr) > s_access_fault (7, mtval=fault_addr) > mret > interrupt.
- Interrupt pending = mstatus.MIE & mie[16+i] & irq_in[i]; lowest i wins; mcause = 32'h8000_0000 | (16+i), mtval 0, mepc = epc_next.
- Exception: mepc = epc_cur.
- FSM IDLE -> TRAP on any trap event; IDLE -> RET on mret; TRAP -> IDLE; RET -> IDLE. Inputs other than CSR reads ignored outside IDLE.
- Detection cycle (IDLE, event present): all four flushes high; regwrite_cancel high for exceptions only. Edge: trap writes mepc/mcause/mtval, MPIE<=MIE, MIE<=0; mret writes MIE<=MPIE, MPIE<=1.
- TRAP: redirect_valid=1, all flushes high, pc_redirect = {mtvec[31:2],2'b00}, plus 4*(cause&31) when mtvec[1:0]==01 and cause is an interrupt. mtvec[1:0] of 1x treated as direct.
- RET: redirect_valid=1, flushes high, pc_redirect = mepc.
- CSR write commits at the edge only when state IDLE, csr_rw=1, mode!=00 and no trap/mret detected that cycle. Set: reg|wdata; clear: reg&~wdata.

## Timing
- Reset: all CSRs 0 except mtvec=RESET_MTVEC; state IDLE; redirect_valid, flushes, regwrite_cancel, trap_busy 0; pc_redirect 0.
- csr_rdata, flushes, regwrite_cancel combinational in detection cycle; redirect exactly one cycle later, lasting one cycle; return to IDLE the following cycle.
- Back-to-back: a new event is accepted no earlier than the cycle after RET/TRAP (2-cycle spacing).
- CSR read in TRAP/RET returns post-update values.
- rst during TRAP/RET aborts: next cycle IDLE, no redirect.
- Interrupt enabled by a CSR write is eligible from the following cycle.

## Test plan
- mtvec=0x100 direct; illegal_inst with epc_cur=0x40, inst_bits=0xFFFF_FFFF -> flushes+cancel cycle 0; cycle 1 redirect 0x100, mepc=0x40, mcause=2, mtval=0xFFFF_FFFF, MIE=0, MPIE=old MIE.
- MIE=1, mie bit17, mtvec=0x201 vectored, irq_in=4'b0110, epc_next=0x88 -> cause 0x8000_0011, redirect 0x244, mepc=0x88, no regwrite_cancel.
- ecall_m and irq pending same cycle -> exception wins (cause 11); interrupt taken after mret restores MIE.
- mret with mepc=0x44, MPIE=1 -> redirect 0x44 one cycle later, MIE=1, MPIE=1.
- CSR set 0x300 with 0x8, clear with 0x8; CSR write coincident with l_access_fault -> write suppressed, mcause=5, mtval=fault_addr.
- rst asserted in TRAP -> next cycle redirect_valid=0, mtvec=RESET_MTVEC, all CSRs cleared.

Source files
------------

// File: rtl/trap_unit.sv
// Machine-mode trap controller: owns the M-mode CSRs and sequences trap entry
// and mret through IDLE -> TRAP/RET -> IDLE, with a redirect issued in TRAP/RET.
`timescale 1ns/1ps
module trap_unit #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_rw,
  input  logic [1:0]         csr_wsc_mode,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               illegal_inst,
  input  logic               ecall_m,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               mret,
  input  logic [31:0]        fault_addr,
  input  logic [31:0]        inst_bits,
  input  logic [31:0]        epc_cur,
  input  logic [31:0]        epc_next,
  output logic [31:0]        pc_redirect,
  output logic               redirect_valid,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               flush_em,
  output logic               flush_mw,
  output logic               regwrite_cancel,
  output logic               trap_busy
);
  localparam int unsigned IRQ_BASE = 16;
  localparam logic [31:0] MIE_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << IRQ_BASE);

  typedef enum logic [1:0] {S_IDLE, S_TRAP, S_RET} state_t;

  state_t      r_state;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic        r_redirect_valid;
  logic [31:0] r_pc_redirect;

  logic               w_idle;
  logic               w_exc;
  logic [NUM_IRQ-1:0] w_irq_pend;
  logic               w_irq_hit;
  logic [4:0]         w_irq_code;
  logic               w_take_exc;
  logic               w_take_irq;
  logic               w_take_trap;
  logic               w_take_ret;
  logic [31:0]        w_cause;
  logic [31:0]        w_tval;
  logic [31:0]        w_trap_target;
  logic [31:0]        w_mstatus;
  logic [31:0]        w_mip;
  logic [31:0]        w_csr_new;
  logic               w_csr_we;
  logic               w_flush;

  assign w_idle     = (r_state == S_IDLE);
  assign w_exc      = illegal_inst | ecall_m | l_access_fault | s_access_fault;
  assign w_irq_pend = r_mie[IRQ_BASE +: NUM_IRQ] & irq_in & {NUM_IRQ{r_mstatus_mie}};

  // Lowest-numbered pending line wins.
  always_comb begin
    w_irq_hit  = 1'b0;
    w_irq_code = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (w_irq_pend[i] && !w_irq_hit) begin
        w_irq_hit  = 1'b1;
        w_irq_code = 5'(int'(IRQ_BASE) + i);
      end
    end
  end

  assign w_take_exc  = w_idle & w_exc;
  assign w_take_ret  = w_idle & ~w_exc & mret;
  assign w_take_irq  = w_idle & ~w_exc & ~mret & w_irq_hit;
  assign w_take_trap = w_take_exc | w_take_irq;

  always_comb begin
    w_cause = {1'b1, 26'd0, w_irq_code};
    w_tval  = '0;
    if (illegal_inst) begin
      w_cause = 32'd2;
      w_tval  = inst_bits;
    end else if (ecall_m) begin
      w_cause = 32'd11;
    end else if (l_access_fault) begin
      w_cause = 32'd5;
      w_tval  = fault_addr;
    end else if (s_access_fault) begin
      w_cause = 32'd7;
      w_tval  = fault_addr;
    end
  end

  // Vectored offset only for interrupts; mtvec mode 1x falls back to direct.
  assign w_trap_target = {r_mtvec[31:2], 2'b00} +
                         ((w_take_irq && r_mtvec[1:0] == 2'b01) ? 32'({w_irq_code, 2'b00}) : 32'd0);

  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mip     = 32'(irq_in) << IRQ_BASE;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = w_mstatus;
      12'h304: csr_rdata = r_mie;
      12'h305: csr_rdata = r_mtvec;
      12'h340: csr_rdata = r_mscratch;
      12'h341: csr_rdata = r_mepc;
      12'h342: csr_rdata = r_mcause;
      12'h343: csr_rdata = r_mtval;
      12'h344: csr_rdata = w_mip;
      default: csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (csr_wsc_mode)
      2'b01:   w_csr_new = csr_wdata;
      2'b10:   w_csr_new = csr_rdata | csr_wdata;
      2'b11:   w_csr_new = csr_rdata & ~csr_wdata;
      default: w_csr_new = csr_rdata;
    endcase
  end

  assign w_csr_we = w_idle & csr_rw & (csr_wsc_mode != 2'b00) & ~w_take_trap & ~w_take_ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_mstatus_mie    <= 1'b0;
      r_mstatus_mpie   <= 1'b0;
      r_mie            <= '0;
      r_mtvec          <= RESET_MTVEC;
      r_mscratch       <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_redirect_valid <= 1'b0;
      r_pc_redirect    <= '0;
    end else begin
      r_redirect_valid <= 1'b0;
      r_pc_redirect    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_take_trap) begin
            r_state          <= S_TRAP;
            r_mepc           <= (w_take_exc ? epc_cur : epc_next) & ~32'd3;
            r_mcause         <= w_cause;
            r_mtval          <= w_tval;
            r_mstatus_mpie   <= r_mstatus_mie;
            r_mstatus_mie    <= 1'b0;
            r_redirect_valid <= 1'b1;
            r_pc_redirect    <= w_trap_target;
          end else if (w_take_ret) begin
            r_state          <= S_RET;
            r_mstatus_mie    <= r_mstatus_mpie;
            r_mstatus_mpie   <= 1'b1;
            r_redirect_valid <= 1'b1;
            r_pc_redirect    <= r_mepc;
          end else if (w_csr_we) begin
            case (csr_addr)
              12'h300: begin
                r_mstatus_mie  <= w_csr_new[3];
                r_mstatus_mpie <= w_csr_new[7];
              end
              12'h304: r_mie      <= w_csr_new & MIE_MASK;
              12'h305: r_mtvec    <= w_csr_new;
              12'h340: r_mscratch <= w_csr_new;
              12'h341: r_mepc     <= w_csr_new & ~32'd3;
              12'h342: r_mcause   <= w_csr_new;
              12'h343: r_mtval    <= w_csr_new;
              default: ;
            endcase
          end
        end
        S_TRAP:  r_state <= S_IDLE;
        S_RET:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_flush         = w_take_trap | w_take_ret | ~w_idle;
  assign flush_fd        = w_flush;
  assign flush_de        = w_flush;
  assign flush_em        = w_flush;
  assign flush_mw        = w_flush;
  assign regwrite_cancel = w_take_exc;
  assign trap_busy       = ~w_idle;
  assign redirect_valid  = r_redirect_valid;
  assign pc_redirect     = r_pc_redirect;
endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: expectations queued at stimulus time and
// popped in order as DUT outputs are sampled on the low clock phase.
`timescale 1ns/1ps
module tb_trap_unit;
  localparam int unsigned NIRQ      = 4;
  localparam logic [31:0] RST_MTVEC = 32'h0000_1000;

  logic            clk = 1'b0;
  logic            rst;
  logic            csr_rw;
  logic [1:0]      csr_wsc_mode;
  logic [11:0]     csr_addr;
  logic [31:0]     csr_wdata;
  logic [31:0]     csr_rdata;
  logic [NIRQ-1:0] irq_in;
  logic            illegal_inst, ecall_m, l_access_fault, s_access_fault, mret;
  logic [31:0]     fault_addr, inst_bits, epc_cur, epc_next, pc_redirect;
  logic            redirect_valid, flush_fd, flush_de, flush_em, flush_mw;
  logic            regwrite_cancel, trap_busy;

  trap_unit #(.NUM_IRQ(NIRQ), .RESET_MTVEC(RST_MTVEC)) dut (
    .clk(clk), .rst(rst), .csr_rw(csr_rw), .csr_wsc_mode(csr_wsc_mode),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .irq_in(irq_in), .illegal_inst(illegal_inst), .ecall_m(ecall_m),
    .l_access_fault(l_access_fault), .s_access_fault(s_access_fault),
    .mret(mret), .fault_addr(fault_addr), .inst_bits(inst_bits),
    .epc_cur(epc_cur), .epc_next(epc_next), .pc_redirect(pc_redirect),
    .redirect_valid(redirect_valid), .flush_fd(flush_fd), .flush_de(flush_de),
    .flush_em(flush_em), .flush_mw(flush_mw), .regwrite_cancel(regwrite_cancel),
    .trap_busy(trap_busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Control bits {busy, redirect, cancel, fd, de, em, mw}.
  localparam logic [31:0] C_IDLE    = 32'h00;
  localparam logic [31:0] C_DET_EXC = 32'h1F;
  localparam logic [31:0] C_DET     = 32'h0F;
  localparam logic [31:0] C_REDIR   = 32'h6F;

  function automatic logic [31:0] ctl();
    return 32'({trap_busy, redirect_valid, regwrite_cancel, flush_fd, flush_de, flush_em, flush_mw});
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic obs_ctl();
    check(ctl());
  endtask

  task automatic obs_pc();
    check(pc_redirect);
  endtask

  task automatic obs_csr(input logic [11:0] a);
    csr_addr = a;
    #1;
    check(csr_rdata);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
    csr_rw       = 1'b1;
    csr_wsc_mode = m;
    csr_addr     = a;
    csr_wdata    = d;
    cyc();
    csr_rw       = 1'b0;
    csr_wsc_mode = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csr_rw = 1'b0; csr_wsc_mode = 2'b00; csr_addr = '0; csr_wdata = '0;
    irq_in = '0; illegal_inst = 1'b0; ecall_m = 1'b0; l_access_fault = 1'b0;
    s_access_fault = 1'b0; mret = 1'b0; fault_addr = '0; inst_bits = '0;
    epc_cur = '0; epc_next = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    push("rst_ctl", C_IDLE); push("rst_pc", 32'h0);
    push("rst_mtvec", RST_MTVEC); push("rst_mstatus", 32'h1800);
    #1 obs_ctl(); obs_pc(); obs_csr(12'h305); obs_csr(12'h300);

    // Basic CSR writes
    csr_wr(12'h305, 2'b01, 32'h100);
    csr_wr(12'h300, 2'b10, 32'h8);
    csr_wr(12'h7C0, 2'b01, 32'hFFFF);
    push("mtvec_wr", 32'h100); push("ms_set", 32'h1808); push("unmapped", 32'h0);
    #1 obs_csr(12'h305); obs_csr(12'h300); obs_csr(12'h7C0);

    // Illegal instruction, direct mtvec; held high into TRAP where it is ignored
    illegal_inst = 1'b1; epc_cur = 32'h40; inst_bits = 32'hFFFF_FFFF;
    push("ill_det", C_DET_EXC);
    push("ill_ctl", C_REDIR); push("ill_pc", 32'h100); push("ill_mepc", 32'h40);
    push("ill_mcause", 32'd2); push("ill_mtval", 32'hFFFF_FFFF); push("ill_ms", 32'h1880);
    push("ill_idle", C_IDLE); push("ill_mscratch", 32'h0); push("ill_mcause2", 32'd2);
    #1 obs_ctl();
    cyc();
    #1 obs_ctl(); obs_pc(); obs_csr(12'h341); obs_csr(12'h342); obs_csr(12'h343); obs_csr(12'h300);
    csr_addr = 12'h340; csr_rw = 1'b1; csr_wsc_mode = 2'b01; csr_wdata = 32'hAAAA;
    cyc();
    illegal_inst = 1'b0; csr_rw = 1'b0; csr_wsc_mode = 2'b00;
    #1 obs_ctl(); obs_csr(12'h340); obs_csr(12'h342);

    // mret with mepc low bits masked
    csr_wr(12'h341, 2'b01, 32'h47);
    push("mepc_mask", 32'h44);
    #1 obs_csr(12'h341);
    mret = 1'b1;
    push("ret_det", C_DET); push("ret_ctl", C_REDIR); push("ret_pc", 32'h44);
    push("ret_ms", 32'h1888); push("ret_idle", C_IDLE);
    #1 obs_ctl();
    cyc();
    mret = 1'b0;
    #1 obs_ctl(); obs_pc(); obs_csr(12'h300);
    cyc();
    #1 obs_ctl();

    // Vectored interrupt, lowest enabled pending line
    csr_wr(12'h304, 2'b01, 32'hFFFF_FFFF);
    push("mie_mask", 32'h000F_0000);
    #1 obs_csr(12'h304);
    csr_wr(12'h304, 2'b01, 32'h0002_0000);
    csr_wr(12'h305, 2'b01, 32'h201);
    irq_in = 4'b0110; epc_next = 32'h88; epc_cur = 32'h70;
    push("irq_det", C_DET); push("irq_mip", 32'h0006_0000);
    push("irq_ctl", C_REDIR); push("irq_pc", 32'h244); push("irq_mcause", 32'h8000_0011);
    push("irq_mepc", 32'h88); push("irq_mtval", 32'h0); push("irq_ms", 32'h1880);
    #1 obs_ctl(); obs_csr(12'h344);
    cyc();
    #1 obs_ctl(); obs_pc(); obs_csr(12'h342); obs_csr(12'h341); obs_csr(12'h343); obs_csr(12'h300);
    cyc();
    irq_in = '0;

    // ecall beats a pending interrupt; interrupt taken after mret re-enables MIE
    csr_wr(12'h300, 2'b10, 32'h8);
    ecall_m = 1'b1; irq_in = 4'b0010; epc_cur = 32'h50; epc_next = 32'h90;
    push("ecall_det", C_DET_EXC); push("ecall_ctl", C_REDIR); push("ecall_pc", 32'h200);
    push("ecall_mcause", 32'd11); push("ecall_mepc", 32'h50); push("ecall_masked", C_IDLE);
    #1 obs_ctl();
    cyc();
    ecall_m = 1'b0;
    #1 obs_ctl(); obs_pc(); obs_csr(12'h342); obs_csr(12'h341);
    cyc();
    #1 obs_ctl();
    mret = 1'b1;
    push("ret2_det", C_DET); push("ret2_pc", 32'h50); push("late_irq_det", C_DET);
    push("late_irq_pc", 32'h244); push("late_irq_mcause", 32'h8000_0011); push("late_irq_mepc", 32'h90);
    #1 obs_ctl();
    cyc();
    mret = 1'b0;
    #1 obs_pc();
    cyc();
    #1 obs_ctl();
    cyc();
    #1 obs_pc(); obs_csr(12'h342); obs_csr(12'h341);
    irq_in = '0;
    cyc();

    // mstatus set / clear
    csr_wr(12'h300, 2'b10, 32'h8);
    push("ms_set2", 32'h1888);
    #1 obs_csr(12'h300);
    csr_wr(12'h300, 2'b11, 32'h8);
    push("ms_clr", 32'h1880);
    #1 obs_csr(12'h300);

    // CSR write coincident with load fault (store fault also raised, lower priority)
    csr_rw = 1'b1; csr_wsc_mode = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD;
    l_access_fault = 1'b1; s_access_fault = 1'b1; fault_addr = 32'h1234_5678; epc_cur = 32'h60;
    push("lf_det", C_DET_EXC); push("lf_mcause", 32'd5); push("lf_mtval", 32'h1234_5678);
    push("lf_mepc", 32'h60); push("lf_pc", 32'h200); push("lf_mscratch", 32'h0);
    #1 obs_ctl();
    cyc();
    csr_rw = 1'b0; csr_wsc_mode = 2'b00; l_access_fault = 1'b0; s_access_fault = 1'b0;
    #1 obs_csr(12'h342); obs_csr(12'h343); obs_csr(12'h341); obs_pc();
    cyc();
    #1 obs_csr(12'h340);

    // Reset asserted while in TRAP
    csr_wr(12'h340, 2'b01, 32'h5);
    push("mscratch_wr", 32'h5);
    #1 obs_csr(12'h340);
    illegal_inst = 1'b1; epc_cur = 32'h80;
    cyc();
    illegal_inst = 1'b0; rst = 1'b1;
    push("rstt_in_trap", C_REDIR);
    push("rstt_ctl", C_IDLE); push("rstt_pc", 32'h0); push("rstt_mtvec", RST_MTVEC);
    push("rstt_mepc", 32'h0); push("rstt_mcause", 32'h0); push("rstt_mtval", 32'h0);
    push("rstt_mstatus", 32'h1800); push("rstt_mie", 32'h0); push("rstt_mscratch", 32'h0);
    #1 obs_ctl();
    cyc();
    rst = 1'b0;
    #1 obs_ctl(); obs_pc(); obs_csr(12'h305); obs_csr(12'h341); obs_csr(12'h342);
    obs_csr(12'h343); obs_csr(12'h300); obs_csr(12'h304); obs_csr(12'h340);

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
